i2c_txn_ctrl: RTL
=================

# i2c_txn_ctrl

Transaction-level sequencer sitting directly upstream of `i2c_master`. It accepts one command (7-bit slave address, direction, byte count) and drives the master's byte-strobe interface through START, the address byte, N data bytes and STOP. Write bytes are pulled from a valid/ready stream and read bytes are pushed out as single-cycle valid pulses. It lets the AXI register front-end issue whole I2C transfers without micro-managing each byte.

## Interface
- `TIMEOUT_CYCLES`, default 100000: maximum cycles spent in any wait state before abort (used only with `I2C_TIMEOUT_EN`).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle; accepts a command.
- `cmd_rw` in 1: 0 = write, 1 = read.
- `cmd_addr` in 7: slave address.
- `cmd_len` in 4: data bytes, 0..15 (0 = address-only probe).
- `wr_valid` in 1: write byte available.
- `wr_ready` out 1: write byte consumed this cycle.
- `wr_data` in 8: write byte.
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid.
- `rd_data` out 8: received byte.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse when the transaction ends, after STOP.
- `err` out 1: one-cycle pulse with `done` if the transaction was aborted by timeout.
- `i2c_en` out 1: operation strobe to the master.
- `i2c_start` out 1: qualifies `i2c_en`: START, then send `tx_data`.
- `i2c_stop` out 1: qualifies `i2c_en`: issue STOP.
- `i2c_ack` out 1: for a read strobe, 1 = master ACKs the byte, 0 = NACK.
- `tx_data` out 8: byte to transmit.
- `tx_ready` in 1: master idle, can take a strobe.
- `tx_done` in 1: pulse; transmitted byte finished.
- `rx_data` in 8: received byte.
- `rx_done` in 1: pulse; `rx_data` valid.

## Operation
- Master strobe contract:
  - Strobes are issued only when `tx_ready`=1 and last exactly one cycle.
  - `i2c_en`&`i2c_start` issues START plus the address byte.
  - `i2c_en` alone issues the next data byte (write or read, per the R/W bit of the address byte).
  - `i2c_en`&`i2c_stop` issues STOP.
- Command accept: on the edge where `cmd_valid`&`cmd_ready`, latch `{cmd_addr,cmd_rw}` as the address byte and `cmd_len` into `remain`.
- FSM states:
  - IDLE: `cmd_ready`=1. On accept, go to ADDR.
  - ADDR: while `tx_ready`, drive `i2c_en`=`i2c_start`=1 with `tx_data`=`{addr,rw}`, then go to ADDR_W.
  - ADDR_W: on `tx_done`, go to STOP if `remain`==0; otherwise go to WR or RD per `rw`.
  - WR: when `tx_ready`&`wr_valid`, drive `i2c_en`=1, `tx_data`=`wr_data`, `wr_ready`=1 in the same cycle, decrement `remain`, then go to WR_W.
  - WR_W: on `tx_done`, go to STOP if `remain`==0, else back to WR.
  - RD: while `tx_ready`, drive `i2c_en`=1 with `i2c_ack`=(`remain`>1), decrement `remain`, then go to RD_W.
  - RD_W: on `rx_done`, register `rx_data` into `rd_data` and pulse `rd_valid` the next cycle. Then go to STOP if `remain`==0, else back to RD.
  - STOP: while `tx_ready`, drive `i2c_en`=`i2c_stop`=1, then go to STOP_W.
  - STOP_W: when `tx_ready` returns to 1, pulse `done`, then go to IDLE.
- `tx_data` holds its last value outside strobe cycles. `busy` = (state != IDLE).
- A write stall (`wr_valid`=0) simply waits in WR; no strobe is issued.
- A stray `tx_done`/`rx_done` in a non-wait state is ignored.
- `cmd_valid` while busy is not accepted (`cmd_ready`=0).

## Timing
- Reset values:
  - FSM in IDLE.
  - `cmd_ready`=1 (combinational from IDLE).
  - All other outputs 0, including `tx_data`=0x00 and `rd_data`=0x00.
- A reset mid-transaction returns to IDLE next cycle with no STOP issued; `i2c_master` shares the same reset.
- Accept-to-first-strobe latency is 1 cycle if `tx_ready`=1.
- All strobes, `wr_ready` and `i2c_ack` are combinational from state and inputs. `rd_valid`, `rd_data`, `done` and `err` are registered.
- `rd_valid` rises 1 cycle after `rx_done`.
- `done` rises 1 cycle after `tx_ready` returns in STOP_W.
- `remain` is a 4-bit down-counter and never wraps: it is decremented only when nonzero.

## Configuration
- `I2C_TIMEOUT_EN` defined:
  - A 32-bit counter clears on every state change and increments in ADDR_W, WR, WR_W, RD_W and STOP_W.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to STOP (STOP_W times out to IDLE directly) and sets a sticky abort flag.
  - The following `done` pulse carries `err`=1; the flag clears in IDLE.
- Undefined: no counter is built, `err` is tied to 0, and wait states wait forever.

## Test plan
- Write addr 0x50, len 2, data 0xA5,0x3C, master model acks every byte.
  - Required: strobes {start, `tx_data`=0xA0}, {0xA5}, {0x3C}, {stop}.
  - Required: exactly 2 `wr_ready` pulses and one `done`, `err`=0.
- Read addr 0x68, len 3, model returns 0x11,0x22,0x33.
  - Required: address byte 0xD1; `i2c_ack` 1,1,0 on the three read strobes.
  - Required: `rd_valid` pulses with 0x11,0x22,0x33, each 1 cycle after its `rx_done`.
- Probe with len 0, addr 0x3C.
  - Required: address byte 0x78 goes directly to STOP, then `done`; no `wr_ready` or `rd_valid`.
- Write len 1 with `wr_valid` held low 20 cycles.
  - Required: no data strobe during the stall; strobe in the first cycle `wr_valid`=1; `busy` stays 1.
- Reset asserted in WR_W.
  - Required: next cycle `busy`=0, `cmd_ready`=1, all strobes 0; a new command is then accepted normally.
- With `I2C_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, model never returns `tx_done` after the address.
  - Required: stop strobe issued 50 cycles into ADDR_W, then `done`=`err`=1 together.

Source files
------------

// File: rtl/i2c_txn_ctrl.sv
// i2c_txn_ctrl: sequences START + address, N data bytes and STOP onto i2c_master's strobe port.
// Define I2C_TIMEOUT_EN to build the wait-state timeout/abort logic (limit set by TIMEOUT_CYCLES).
module i2c_txn_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       i2c_en,
    output logic       i2c_start,
    output logic       i2c_stop,
    output logic       i2c_ack,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_W, S_WR, S_WR_W, S_RD, S_RD_W, S_STOP, S_STOP_W
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [3:0] remain_q, remain_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, done_d;
    logic [7:0] tx_byte;

`ifdef I2C_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        abort_q, abort_d;
    logic        err_q, err_d;
    logic        tmo_count;

    assign tmo_count = (state_q == S_ADDR_W) || (state_q == S_WR) || (state_q == S_WR_W) ||
                       (state_q == S_RD_W) || (state_q == S_STOP_W);
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        tx_hold_d  = tx_hold_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        i2c_en     = 1'b0;
        i2c_start  = 1'b0;
        i2c_stop   = 1'b0;
        i2c_ack    = 1'b0;
        wr_ready   = 1'b0;
        tx_byte    = tx_hold_q;
`ifdef I2C_TIMEOUT_EN
        err_d      = 1'b0;
        abort_d    = abort_q;
        tmo_cnt_d  = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d   = {cmd_addr, cmd_rw};
                    remain_d = cmd_len;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (tx_ready) begin
                    i2c_en    = 1'b1;
                    i2c_start = 1'b1;
                    tx_byte   = addr_q;
                    state_d   = S_ADDR_W;
                end
            end
            S_ADDR_W: begin
                if (tx_done) begin
                    if (remain_q == 4'd0) state_d = S_STOP;
                    else                  state_d = addr_q[0] ? S_RD : S_WR;
                end
            end
            S_WR: begin
                if (tx_ready && wr_valid) begin
                    i2c_en   = 1'b1;
                    wr_ready = 1'b1;
                    tx_byte  = wr_data;
                    if (remain_q != 4'd0) remain_d = remain_q - 4'd1;
                    state_d  = S_WR_W;
                end
            end
            S_WR_W: begin
                if (tx_done) state_d = (remain_q == 4'd0) ? S_STOP : S_WR;
            end
            S_RD: begin
                if (tx_ready) begin
                    i2c_en  = 1'b1;
                    // NACK the final byte so the slave releases SDA before STOP
                    i2c_ack = (remain_q > 4'd1);
                    if (remain_q != 4'd0) remain_d = remain_q - 4'd1;
                    state_d = S_RD_W;
                end
            end
            S_RD_W: begin
                if (rx_done) begin
                    rd_data_d  = rx_data;
                    rd_valid_d = 1'b1;
                    state_d    = (remain_q == 4'd0) ? S_STOP : S_RD;
                end
            end
            S_STOP: begin
                if (tx_ready) begin
                    i2c_en   = 1'b1;
                    i2c_stop = 1'b1;
                    state_d  = S_STOP_W;
                end
            end
            S_STOP_W: begin
                if (tx_ready) begin
                    done_d  = 1'b1;
`ifdef I2C_TIMEOUT_EN
                    err_d   = abort_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i2c_en) tx_hold_d = tx_byte;

`ifdef I2C_TIMEOUT_EN
        // Expiry only applies when the wait made no progress this cycle
        if (tmo_count && (tmo_cnt_q >= TMO_LAST) && (state_d == state_q)) begin
            abort_d = 1'b1;
            if (state_q == S_STOP_W) begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_STOP;
            end
        end
        if (state_q == S_IDLE) abort_d = 1'b0;
        if (state_d != state_q)  tmo_cnt_d = 32'd0;
        else if (tmo_count)      tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'h00;
            remain_q   <= 4'd0;
            tx_hold_q  <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef I2C_TIMEOUT_EN
            tmo_cnt_q  <= 32'd0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            tx_hold_q  <= tx_hold_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
`ifdef I2C_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign tx_data   = tx_byte;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
`ifdef I2C_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
